// File: rtl/aes_pkg.sv
// Shared AES helpers for the key schedule: S-box table, GF(2^8) arithmetic,
// key-size derivation and the expansion FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Key length in words, round count and schedule length from the key size.
  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (key_bits / 32 + 7);
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Request/status/read-port bundle of the AES key schedule.
interface aes_key_schedule_if #(
  parameter int KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                done;
  logic [3:0]          rd_round;
  logic                rd_inv;
  logic [127:0]        rd_key;
  logic                rd_valid;

  modport master (
    output start, key_in, rd_round, rd_inv,
    input  busy, done, rd_key, rd_valid
  );

  modport slave (
    input  start, key_in, rd_round, rd_inv,
    output busy, done, rd_key, rd_valid
  );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
  end
endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one word per cycle, with a registered round-key read port.
// Build macro AES_KEY_EQINV_EN adds the equivalent-inverse (InvMixColumns) read path.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic               clk,
  input logic               rest,
  aes_key_schedule_if.slave ks
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam int AW = 6;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e      state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [2:0]     mod_q, mod_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [31:0]    prev_q, prev_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic [127:0]   rd_key_q, rd_key_d;
  logic           rd_valid_q, rd_valid_d;
  logic [31:0]    w_q [NW];

  logic           load, gen;
  logic [31:0]    sub_in, sub_out, temp, new_word;

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge clk) begin
    if (rest) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: combinational blocks use blocking '=' with a default first, so every path assigns and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (ks.start) state_d = ST_EXPAND;
      ST_EXPAND:        if (idx_q == AW'(NW)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ks.busy = (state_q == ST_EXPAND);
    ks.done = (state_q == ST_DONE);
    load    = ks.start && (state_q != ST_EXPAND);
    gen     = (state_q == ST_EXPAND) && (idx_q != AW'(NW));
  end

  // ---------------- Expansion datapath ----------------
  // w[i-1] lives in prev_q; the new word is written one edge later, giving a drain cycle.
  assign sub_in = (mod_q == 3'd0) ? {prev_q[23:0], prev_q[31:24]} : prev_q;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    temp = prev_q;
    if (mod_q == 3'd0)                  temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && mod_q == 3'd4)  temp = sub_out;
  end

  assign new_word = w_q[idx_q - AW'(NK)] ^ temp;

  always_comb begin
    idx_d     = idx_q;
    mod_d     = mod_q;
    rcon_d    = rcon_q;
    prev_d    = prev_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (load) begin
      idx_d  = AW'(NK);
      mod_d  = 3'd0;
      rcon_d = 8'h01;
      prev_d = ks.key_in[31:0];
    end else if (gen) begin
      wr_en_d   = 1'b1;
      wr_addr_d = idx_q;
      wr_data_d = new_word;
      prev_d    = new_word;
      idx_d     = idx_q + AW'(1);
      mod_d     = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
      if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
    end
  end

  // NOTE: the word store has no reset; it is only readable once a full expansion has rewritten it.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NK; k++) w_q[k] <= ks.key_in[KEY_BITS-1-32*k -: 32];
    end
    if (wr_en_q) w_q[wr_addr_q] <= wr_data_q;
  end

  // ---------------- Read port ----------------
  logic [AW-1:0] rd_base;
  logic [127:0]  plain_key, sel_key;

  assign rd_base   = {ks.rd_round, 2'b00};
  assign plain_key = {w_q[rd_base], w_q[rd_base + AW'(1)],
                      w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};

`ifdef AES_KEY_EQINV_EN
  logic [127:0] inv_key;
  always_comb begin
    for (int c = 0; c < 4; c++) inv_key[127-32*c -: 32] = inv_mix_column(plain_key[127-32*c -: 32]);
  end
  assign sel_key = (ks.rd_inv && ks.rd_round != 4'd0 && ks.rd_round < NR_L) ? inv_key : plain_key;
`else
  logic unused_rd_inv;
  assign unused_rd_inv = ks.rd_inv;
  assign sel_key       = plain_key;
`endif

  always_comb begin
    rd_valid_d = (state_q == ST_DONE) && (ks.rd_round <= NR_L);
    rd_key_d   = rd_valid_d ? sel_key : '0;
  end

  assign ks.rd_key   = rd_key_q;
  assign ks.rd_valid = rd_valid_q;

  always_ff @(posedge clk) begin
    if (rest) begin
      idx_q      <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      prev_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      prev_q     <= prev_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: 128/192/256 instances against an independent
// key-expansion model (S-box derived from GF(2^8) inversion) and FIPS-197 vectors.
module tb_aes_key_schedule;

  typedef logic [31:0] sched_t [60];
  typedef struct {
    string        tag;
    logic [127:0] key;
    logic         valid;
    int unsigned  stamp;
  } rd_exp_t;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F128_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F128_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] F192_R12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] F256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rest;
  int unsigned cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] sb [256];
  sched_t s128, s192, s256, s_k2;
  rd_exp_t q128[$], q192[$], q256[$];
  rd_exp_t m_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_schedule_if #(.KEY_BITS(128)) if128 ();
  aes_key_schedule_if #(.KEY_BITS(192)) if192 ();
  aes_key_schedule_if #(.KEY_BITS(256)) if256 ();

  aes_key_schedule #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rest(rest), .ks(if128));
  aes_key_schedule #(.KEY_BITS(192)) u_dut192 (.clk(clk), .rest(rest), .ks(if192));
  aes_key_schedule #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rest(rest), .ks(if256));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic sched_t m_expand(input int nk, input logic [255:0] key);
    sched_t w;
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = m_mul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = m_sub(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return w;
  endfunction

  function automatic logic [127:0] m_rk(input sched_t w, input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_imc(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = k[127-32*c -: 32];
      o[127-32*c -: 32] = {
        m_mul(a0, 8'h0e) ^ m_mul(a1, 8'h0b) ^ m_mul(a2, 8'h0d) ^ m_mul(a3, 8'h09),
        m_mul(a0, 8'h09) ^ m_mul(a1, 8'h0e) ^ m_mul(a2, 8'h0b) ^ m_mul(a3, 8'h0d),
        m_mul(a0, 8'h0d) ^ m_mul(a1, 8'h09) ^ m_mul(a2, 8'h0e) ^ m_mul(a3, 8'h0b),
        m_mul(a0, 8'h0b) ^ m_mul(a1, 8'h0d) ^ m_mul(a2, 8'h09) ^ m_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = m_mul(inv, 8'(x));
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // ---------------- Scoreboard ----------------
  task automatic rd(input int inst, input int r, input logic inv, input logic [127:0] k,
                    input logic v, input string tag);
    rd_exp_t e;
    e.tag = tag; e.key = k; e.valid = v; e.stamp = cyc;
    case (inst)
      0: begin if128.rd_round = 4'(r); if128.rd_inv = inv; q128.push_back(e); end
      1: begin if192.rd_round = 4'(r); if192.rd_inv = inv; q192.push_back(e); end
      default: begin if256.rd_round = 4'(r); if256.rd_inv = inv; q256.push_back(e); end
    endcase
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (q128.size() > 0 && q128[0].stamp < cyc) begin
      m_e = q128.pop_front();
      check({m_e.tag, "_key"}, if128.rd_key, m_e.key);
      check({m_e.tag, "_vld"}, 128'(if128.rd_valid), 128'(m_e.valid));
    end
    if (q192.size() > 0 && q192[0].stamp < cyc) begin
      m_e = q192.pop_front();
      check({m_e.tag, "_key"}, if192.rd_key, m_e.key);
      check({m_e.tag, "_vld"}, 128'(if192.rd_valid), 128'(m_e.valid));
    end
    if (q256.size() > 0 && q256[0].stamp < cyc) begin
      m_e = q256.pop_front();
      check({m_e.tag, "_key"}, if256.rd_key, m_e.key);
      check({m_e.tag, "_vld"}, 128'(if256.rd_valid), 128'(m_e.valid));
    end
  end

  task automatic start128_and_wait(input logic [127:0] key, input string tag);
    int lat;
    lat = -1;
    if128.key_in = key;
    if128.start  = 1'b1;
    @(negedge clk);
    if128.start  = 1'b0;
    if128.key_in = ~key;
    check({tag, "_busy"}, 128'(if128.busy), 128'd1);
    check({tag, "_done"}, 128'(if128.done), 128'd0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 40) check({tag, "_done_c40"}, 128'(if128.done), 128'd0);
      if (if128.done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, 128'(lat), 128'd41);
  endtask

  task automatic read_all128(input sched_t s, input string tag);
    for (int r = 0; r <= 10; r++) rd(0, r, 1'b0, m_rk(s, r), 1'b1, $sformatf("%s_r%0d", tag, r));
  endtask

  initial begin
    int lat128, lat192, lat256;
    logic [127:0] exp_k;

    build_sbox();
    s128 = m_expand(4, {K128, 128'h0});
    s192 = m_expand(6, {K192, 64'h0});
    s256 = m_expand(8, K256);
    s_k2 = m_expand(4, {K2, 128'h0});

    rest = 1'b1;
    if128.start = 1'b0; if128.key_in = '0; if128.rd_round = '0; if128.rd_inv = 1'b0;
    if192.start = 1'b0; if192.key_in = '0; if192.rd_round = '0; if192.rd_inv = 1'b0;
    if256.start = 1'b0; if256.key_in = '0; if256.rd_round = '0; if256.rd_inv = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy",  128'(if128.busy),     128'd0);
    check("rst_done",  128'(if128.done),     128'd0);
    check("rst_vld",   128'(if128.rd_valid), 128'd0);
    check("rst_key",   if128.rd_key,         128'd0);
    check("rst_done192", 128'(if192.done),   128'd0);
    check("rst_done256", 128'(if256.done),   128'd0);
    rest = 1'b0;
    @(negedge clk);

    // Concurrent expansion on all key sizes; a stray start hits the 128-bit engine mid-expansion.
    if128.key_in = K128; if192.key_in = K192; if256.key_in = K256;
    if128.start = 1'b1;  if192.start = 1'b1;  if256.start = 1'b1;
    @(negedge clk);
    if128.start = 1'b0;  if192.start = 1'b0;  if256.start = 1'b0;
    if128.key_in = ~K128; if192.key_in = ~K192; if256.key_in = ~K256;
    check("exp_busy", 128'(if128.busy), 128'd1);
    check("exp_done", 128'(if128.done), 128'd0);
    lat128 = -1; lat192 = -1; lat256 = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin
        if128.key_in = 128'hdeadbeef_01234567_89abcdef_feedface;
        if128.start  = 1'b1;
      end
      if (c == 11) if128.start = 1'b0;
      @(negedge clk);
      if (lat128 < 0 && if128.done) lat128 = c;
      if (lat192 < 0 && if192.done) lat192 = c;
      if (lat256 < 0 && if256.done) lat256 = c;
    end
    check("lat128", 128'(lat128), 128'd41);
    check("lat192", 128'(lat192), 128'd47);
    check("lat256", 128'(lat256), 128'd53);
    check("done_hold", 128'(if128.done), 128'd1);
    check("done_busy", 128'(if128.busy), 128'd0);

    read_all128(s128, "k128");
    rd(0, 1,  1'b0, F128_R1,  1'b1, "k128_fips_r1");
    rd(0, 10, 1'b0, F128_R10, 1'b1, "k128_fips_r10");
    rd(0, 11, 1'b0, 128'h0,   1'b0, "k128_r11");
    rd(0, 15, 1'b0, 128'h0,   1'b0, "k128_r15");
    for (int r = 0; r <= 10; r++) begin
      exp_k = m_rk(s128, r);
`ifdef AES_KEY_EQINV_EN
      if (r >= 1 && r <= 9) exp_k = m_imc(exp_k);
`endif
      rd(0, r, 1'b1, exp_k, 1'b1, $sformatf("k128_inv_r%0d", r));
    end
    if128.rd_inv = 1'b0;

    for (int r = 0; r <= 12; r++) rd(1, r, 1'b0, m_rk(s192, r), 1'b1, $sformatf("k192_r%0d", r));
    rd(1, 12, 1'b0, F192_R12, 1'b1, "k192_fips_r12");
    rd(1, 13, 1'b0, 128'h0,   1'b0, "k192_r13");
    for (int r = 0; r <= 14; r++) rd(2, r, 1'b0, m_rk(s256, r), 1'b1, $sformatf("k256_r%0d", r));
    rd(2, 14, 1'b0, F256_R14, 1'b1, "k256_fips_r14");
    rd(2, 15, 1'b0, 128'h0,   1'b0, "k256_r15");

    // Abort an expansion with rest, then expand a new key from scratch.
    if128.key_in = K2;
    if128.start  = 1'b1;
    @(negedge clk);
    if128.start  = 1'b0;
    rd(0, 0, 1'b0, 128'h0, 1'b0, "k2_rd_busy");
    repeat (19) @(negedge clk);
    rest = 1'b1;
    @(negedge clk);
    rest = 1'b0;
    check("abort_busy", 128'(if128.busy), 128'd0);
    check("abort_done", 128'(if128.done), 128'd0);
    check("abort_vld",  128'(if128.rd_valid), 128'd0);
    repeat (5) @(negedge clk);
    check("abort_idle_busy", 128'(if128.busy), 128'd0);
    check("abort_idle_done", 128'(if128.done), 128'd0);

    start128_and_wait(K2, "k2");
    read_all128(s_k2, "k2");

    // Restart from DONE with the FIPS key.
    start128_and_wait(K128, "restart");
    read_all128(s128, "restart");
    rd(0, 10, 1'b0, F128_R10, 1'b1, "restart_fips_r10");

    repeat (3) @(negedge clk);
    check("sb_drain", 128'(q128.size() + q192.size() + q256.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Parametrised AES key-expansion engine supporting AES-128/192/256, selected by KEY_BITS at elaboration. It generates one 32-bit schedule word per cycle into an internal round-key store after a start pulse, then serves any round key by index through a registered read port. It sits beside the AES encryption/decryption datapaths as the shared round-key source, so decryption can fetch keys in reverse order.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128/192/256, any other value is an elaboration error.
NK (derived, localparam), KEY_BITS/32, key length in words (4/6/8).
NR (derived, localparam), NK+6, round count (10/12/14).
NW (derived, localparam), 4*(NR+1), total schedule words (44/52/60).

Ports:
clk  in  1  clock; all logic on the rising edge.
rest  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to expand key_in.
key_in  in  KEY_BITS  cipher key; word 0 = bits [KEY_BITS-1 -: 32].
busy  out  1  expansion in progress.
done  out  1  schedule complete and readable.
rd_round  in  4  round-key index 0..NR.
rd_inv  in  1  request equivalent-inverse key (see Optional Feature).
rd_key  out  128  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
rd_valid  out  1  rd_key holds a legal key.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, rd_key=0, rd_valid=0, word index=0, rcon=8'h01. Word store is not cleared.
- FSM states: IDLE, EXPAND, DONE.
- IDLE: on start, capture key_in into w[0..NK-1], set i=NK, rcon=8'h01, and a modulo-NK counter=0. Next state is EXPAND and busy=1.
- EXPAND: each cycle write w[i] = w[i-NK] ^ temp, where temp is selected as follows:
  - i mod NK==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon <= xtime(rcon).
  - NK==8 and i mod NK==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - Use a wrapping modulo counter; no divider.
- When w[NW-1] is written: state=DONE, busy=0, done=1.
- Latency: done rises NW-NK+1 edges after the edge that sampled start, i.e. 41/47/53 cycles for 128/192/256.
- DONE: done stays high. A start in DONE restarts exactly as from IDLE; done=0 and busy=1 on the following cycle.
- start while in EXPAND is ignored; the expansion in progress continues unaffected.
- Read port, 1-cycle registered latency:
  - When done=1 and rd_round<=NR: rd_key <= selected key and rd_valid <= 1.
  - When rd_round>NR or done=0: rd_key <= 0 and rd_valid <= 0.
- rest asserted mid-expansion aborts immediately to the reset values. A fresh start is required afterwards.
- key_in is sampled only on the start cycle and may change afterwards.

Optional Feature:
Macro AES_KEY_EQINV_EN.
- Defined: when rd_inv=1 and 1<=rd_round<=NR-1, rd_key returns InvMixColumns of the stored round key, computed combinationally on the read path before the output register, for the FIPS-197 equivalent inverse cipher. Rounds 0 and NR are returned unchanged. Latency is unchanged.
- Not defined: rd_inv is ignored, no InvMixColumns logic is synthesised, and rd_key is always the plain key.

Decomposition:
- Package aes_pkg: S-box table function, xtime/gmul helpers, the KEY_BITS-to-NK/NR/NW derivation function, and the FSM state enum.
- One sub-module, aes_sub_word: four parallel S-box lookups, combinational, 32-bit in/out. It is instantiated once in the expansion path.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done after 41 cycles. Round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles; round 12 = e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles; round 14 = fe4890d1e6188d0b046df344706c631e.
- KEY_BITS=128: rd_round=11 -> rd_key=0 and rd_valid=0. start pulsed mid-EXPAND -> ignored, done still at cycle 41 with correct keys.
- rest asserted at cycle 20 of an expansion -> busy=0, done=0 next cycle. A subsequent start with a new key produces correct keys after a full 41 cycles. A start in DONE drops done for one full re-expansion.
- With AES_KEY_EQINV_EN, 128-bit FIPS key, rd_inv=1, rd_round=1 -> rd_key = InvMixColumns(a0fafe17...2a6c7605) as computed by the reference model. rd_round=0 and rd_round=10 return the plain keys.
